// File: rtl/du_pkg.sv
// Shared widths, command bytes and one-hot state encodings for the debug-unit command front end.
package du_pkg;

   localparam int unsigned NB_UART_DATA = 8;
   localparam int unsigned NB_INSTR     = 32;
   localparam int unsigned NB_IMEM_ADDR = 10;
   localparam int unsigned NB_LEN       = 16;

   localparam logic [NB_UART_DATA-1:0] CMD_LOAD = 8'h4C;
   localparam logic [NB_UART_DATA-1:0] CMD_RUN  = 8'h52;
   localparam logic [NB_UART_DATA-1:0] CMD_STEP = 8'h53;
   localparam logic [NB_UART_DATA-1:0] CMD_DUMP = 8'h44;

   typedef logic [6:0] du_state_t;

   localparam du_state_t ST_IDLE       = 7'b000_0001;
   localparam du_state_t ST_LOAD_LEN   = 7'b000_0010;
   localparam du_state_t ST_LOAD_DATA  = 7'b000_0100;
   localparam du_state_t ST_RUN        = 7'b000_1000;
   localparam du_state_t ST_STEP       = 7'b001_0000;
   localparam du_state_t ST_DUMP_START = 7'b010_0000;
   localparam du_state_t ST_DUMP_WAIT  = 7'b100_0000;

endpackage

// File: rtl/du_cmd_decoder_if.sv
// RX FIFO read port: first-word-fall-through head byte, empty flag and pop strobe.
interface du_cmd_decoder_if;
   import du_pkg::*;

   logic                    rx_empty;
   logic [NB_UART_DATA-1:0] rx_data;
   logic                    rx_rd;

   modport master (output rx_empty, output rx_data, input rx_rd);
   modport slave  (input rx_empty, input rx_data, output rx_rd);

endinterface

// File: rtl/du_word_assembler.sv
// Packs four little-endian bytes into one instruction word; word_valid pulses the cycle after byte 4.
module du_word_assembler
   import du_pkg::*;
(
   input  logic                    clk,
   input  logic                    i_rst,
   input  logic                    i_byte_valid,
   input  logic [NB_UART_DATA-1:0] i_byte,
   output logic [1:0]              o_byte_cnt,
   output logic                    o_word_valid,
   output logic [NB_INSTR-1:0]     o_word
);

   logic [1:0]          cnt_q, cnt_d;
   logic [NB_INSTR-1:0] word_q, word_d;
   logic                valid_q, valid_d;

   always_comb begin
      cnt_d   = cnt_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (i_byte_valid) begin
         // Shift right so the first byte ends up in bits [7:0].
         word_d  = {i_byte, word_q[NB_INSTR-1:NB_UART_DATA]};
         cnt_d   = cnt_q + 2'd1;
         valid_d = (cnt_q == 2'd3);
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         cnt_q   <= 2'd0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign o_byte_cnt   = cnt_q;
   assign o_word_valid = valid_q;
   assign o_word       = word_q;

endmodule

// File: rtl/du_cmd_decoder.sv
// Debug-unit command FSM: load program words, run/step the CPU and trigger register dumps.
module du_cmd_decoder
   import du_pkg::*;
(
   input  logic                    clk,
   input  logic                    i_rst,
   du_cmd_decoder_if.slave         rx,
   output logic                    o_imem_wr,
   output logic [NB_IMEM_ADDR-1:0] o_imem_waddr,
   output logic [NB_INSTR-1:0]     o_imem_wdata,
   output logic                    o_cpu_en,
   input  logic                    i_cpu_halt,
   output logic                    o_regfile_tx_start,
   input  logic                    i_regfile_tx_done,
   output logic                    o_load_done,
   output logic                    o_busy
);

   du_state_t               state_q, state_d;
   logic [NB_LEN-1:0]       len_q, len_d;
   logic                    len_hi_q, len_hi_d;
   logic [NB_LEN-1:0]       words_q, words_d;
   logic [NB_IMEM_ADDR-1:0] waddr_q, waddr_d;
   logic                    load_done_q, load_done_d;
   logic                    cpu_en_q, cpu_en_d;
   logic                    rx_rd;
   logic [1:0]              byte_cnt;
   logic                    word_valid;
   logic [NB_INSTR-1:0]     word;

   du_word_assembler u_asm (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_byte_valid(rx_rd && (state_q == ST_LOAD_DATA)),
      .i_byte      (rx.rx_data),
      .o_byte_cnt  (byte_cnt),
      .o_word_valid(word_valid),
      .o_word      (word)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      len_hi_d    = len_hi_q;
      words_d     = words_q;
      waddr_d     = waddr_q;
      load_done_d = 1'b0;
      rx_rd       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!rx.rx_empty) begin
               rx_rd = 1'b1;
               case (rx.rx_data)
                  CMD_LOAD: begin
                     state_d  = ST_LOAD_LEN;
                     len_hi_d = 1'b0;
                     waddr_d  = '0;
                     words_d  = '0;
                  end
                  CMD_RUN:  state_d = ST_RUN;
                  CMD_STEP: state_d = ST_STEP;
                  CMD_DUMP: state_d = ST_DUMP_START;
                  default:  ;
               endcase
            end
         end
         ST_LOAD_LEN: begin
            if (!rx.rx_empty) begin
               rx_rd = 1'b1;
               if (!len_hi_q) begin
                  len_d    = {len_q[NB_LEN-1:NB_UART_DATA], rx.rx_data};
                  len_hi_d = 1'b1;
               end else begin
                  len_d = {rx.rx_data, len_q[NB_UART_DATA-1:0]};
                  if ({rx.rx_data, len_q[NB_UART_DATA-1:0]} == '0) begin
                     state_d     = ST_IDLE;
                     load_done_d = 1'b1;
                  end else begin
                     state_d = ST_LOAD_DATA;
                  end
               end
            end
         end
         ST_LOAD_DATA: begin
            // words_q counts words fully popped; stop popping once all N are in.
            if (!rx.rx_empty && (words_q != len_q)) begin
               rx_rd = 1'b1;
               if (byte_cnt == 2'd3) words_d = words_q + 1'b1;
            end
            if (word_valid) begin
               waddr_d = waddr_q + 1'b1;
               if (words_q == len_q) begin
                  state_d     = ST_IDLE;
                  load_done_d = 1'b1;
               end
            end
         end
         ST_RUN:        if (i_cpu_halt) state_d = ST_DUMP_START;
         ST_STEP:       state_d = ST_DUMP_START;
         ST_DUMP_START: state_d = ST_DUMP_WAIT;
         ST_DUMP_WAIT:  if (i_regfile_tx_done) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
      // Registered enable: halt seen this cycle gates the CPU from the next cycle on.
      cpu_en_d = ((state_d == ST_RUN) && !i_cpu_halt) || (state_d == ST_STEP);
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         len_hi_q    <= 1'b0;
         words_q     <= '0;
         waddr_q     <= '0;
         load_done_q <= 1'b0;
         cpu_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         len_hi_q    <= len_hi_d;
         words_q     <= words_d;
         waddr_q     <= waddr_d;
         load_done_q <= load_done_d;
         cpu_en_q    <= cpu_en_d;
      end
   end

   assign rx.rx_rd             = rx_rd && !i_rst;
   assign o_imem_wr            = word_valid;
   assign o_imem_waddr         = waddr_q;
   assign o_imem_wdata         = word;
   assign o_cpu_en             = cpu_en_q;
   assign o_regfile_tx_start   = (state_q == ST_DUMP_START);
   assign o_load_done          = load_done_q;
   assign o_busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_du_cmd_decoder.sv
// Bench for du_cmd_decoder: FIFO model, event logs and a command-stream reference model.
module tb_du_cmd_decoder;
   import du_pkg::*;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_cpu_halt;
   logic        i_regfile_tx_done;
   logic        o_imem_wr;
   logic [9:0]  o_imem_waddr;
   logic [31:0] o_imem_wdata;
   logic        o_cpu_en;
   logic        o_regfile_tx_start;
   logic        o_load_done;
   logic        o_busy;

   du_cmd_decoder_if rx_if ();

   du_cmd_decoder dut (
      .clk               (clk),
      .i_rst             (i_rst),
      .rx                (rx_if),
      .o_imem_wr         (o_imem_wr),
      .o_imem_waddr      (o_imem_waddr),
      .o_imem_wdata      (o_imem_wdata),
      .o_cpu_en          (o_cpu_en),
      .i_cpu_halt        (i_cpu_halt),
      .o_regfile_tx_start(o_regfile_tx_start),
      .i_regfile_tx_done (i_regfile_tx_done),
      .o_load_done       (o_load_done),
      .o_busy            (o_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0]  fifo[$];
   logic [7:0]  stim[$];
   int          gap_len = 0;
   int          gap_cnt = 0;
   bit          popped  = 1'b0;

   int          pop_cyc[$];
   int          wr_cyc[$];
   logic [9:0]  wr_addr[$];
   logic [31:0] wr_data[$];
   int          done_cyc[$];
   int          start_cyc[$];
   int          en_cyc[$];
   int          busy_n;

   logic [9:0]  exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_done, exp_start, exp_en;

   // One clock: retire last cycle's pop, present the new FIFO head, then log this cycle's outputs.
   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (popped && fifo.size() > 0) begin
         void'(fifo.pop_front());
         gap_cnt = gap_len;
      end else if (gap_cnt > 0) begin
         gap_cnt--;
      end
      rx_if.rx_empty = (fifo.size() == 0) || (gap_cnt > 0);
      rx_if.rx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
      @(negedge clk);
      popped = rx_if.rx_rd;
      if (rx_if.rx_rd) pop_cyc.push_back(cyc);
      if (o_imem_wr) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(o_imem_waddr);
         wr_data.push_back(o_imem_wdata);
      end
      if (o_load_done)        done_cyc.push_back(cyc);
      if (o_regfile_tx_start) start_cyc.push_back(cyc);
      if (o_cpu_en)           en_cyc.push_back(cyc);
      if (o_busy)             busy_n++;
   endtask

   task automatic clear_log();
      pop_cyc.delete(); wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
      done_cyc.delete(); start_cyc.delete(); en_cyc.delete(); busy_n = 0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int quiet = 0;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (fifo.size() == 0 && !o_busy && !popped) quiet++;
         else quiet = 0;
         if (quiet >= 3) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_pops(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (pop_cyc.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Reference: interpret the byte stream as commands (halt held high, so 'R' never enables).
   function automatic void model_stream(input logic [7:0] s[$]);
      int i = 0;
      exp_addr.delete(); exp_data.delete();
      exp_done = 0; exp_start = 0; exp_en = 0;
      while (i < s.size()) begin
         logic [7:0] b = s[i];
         i++;
         if (b == 8'h4C) begin
            int n = int'(s[i]) + 256 * int'(s[i+1]);
            i += 2;
            for (int w = 0; w < n; w++) begin
               exp_addr.push_back(10'(w % 1024));
               exp_data.push_back({s[i+3], s[i+2], s[i+1], s[i]});
               i += 4;
            end
            exp_done++;
         end else if (b == 8'h52 || b == 8'h44) begin
            exp_start++;
         end else if (b == 8'h53) begin
            exp_start++;
            exp_en++;
         end
      end
   endfunction

   task automatic push_stim();
      foreach (stim[i]) fifo.push_back(stim[i]);
   endtask

   task automatic test_reset();
      logic [46:0] obs;
      i_rst = 1'b1;
      fifo.push_back(8'h44);
      for (int i = 0; i < 3; i++) cycle();
      obs = {o_imem_wr, o_imem_waddr, o_imem_wdata, o_cpu_en, o_regfile_tx_start,
             o_load_done, o_busy};
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, want 0", obs);
      end
      n_checks++;
      if (rx_if.rx_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_pop: rx_rd=%b, want 0", rx_if.rx_rd);
      end
      fifo.delete();
      rx_if.rx_empty = 1'b1;
      cycle();
      i_rst = 1'b0;
   endtask

   task automatic test_load_two();
      bit ok;
      clear_log();
      stim = '{8'h4C, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      model_stream(stim);
      push_stim();
      wait_idle(100, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL load2_idle: not idle, want idle"); end
      n_checks++;
      if (wr_addr.size() != 2) begin
         n_fail++; $display("FAIL load2_nwr: got %0d writes, want 2", wr_addr.size());
      end
      for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
         n_checks++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL load2_word%0d: got %h@%0d, want %h@%0d", i, wr_data[i], wr_addr[i],
                     exp_data[i], exp_addr[i]);
         end
      end
      n_checks++;
      if (done_cyc.size() != 1) begin
         n_fail++; $display("FAIL load2_done: got %0d pulses, want 1", done_cyc.size());
      end
      n_checks++;
      if (pop_cyc.size() != 11 || wr_cyc.size() != 2 || done_cyc.size() != 1) begin
         n_fail++; $display("FAIL load2_latency: pops=%0d wr=%0d, want 11 and 2",
                            pop_cyc.size(), wr_cyc.size());
      end else if (wr_cyc[0] != pop_cyc[6] + 1 || wr_cyc[1] != pop_cyc[10] + 1 ||
                   done_cyc[0] != wr_cyc[1] + 1) begin
         n_fail++;
         $display("FAIL load2_latency: wr@%0d,%0d done@%0d, want %0d,%0d,%0d", wr_cyc[0],
                  wr_cyc[1], done_cyc[0], pop_cyc[6] + 1, pop_cyc[10] + 1, wr_cyc[1] + 1);
      end
   endtask

   task automatic test_load_zero();
      bit ok;
      clear_log();
      stim = '{8'h4C, 8'h00, 8'h00};
      push_stim();
      wait_idle(40, ok);
      n_checks++;
      if (!ok || wr_cyc.size() != 0) begin
         n_fail++; $display("FAIL load0_nwr: idle=%0b writes=%0d, want 1 and 0", ok,
                            wr_cyc.size());
      end
      n_checks++;
      if (done_cyc.size() != 1 || pop_cyc.size() != 3) begin
         n_fail++; $display("FAIL load0_done: pulses=%0d pops=%0d, want 1 and 3",
                            done_cyc.size(), pop_cyc.size());
      end else if (done_cyc[0] != pop_cyc[2] + 1) begin
         n_fail++; $display("FAIL load0_latency: got %0d, want %0d", done_cyc[0], pop_cyc[2] + 1);
      end
   endtask

   task automatic test_run();
      bit ok;
      int t;
      clear_log();
      i_cpu_halt = 1'b0;
      i_regfile_tx_done = 1'b0;
      fifo.push_back(8'h52);
      wait_pops(1, 20, ok);
      t = ok ? pop_cyc[0] : cyc;
      while (cyc < t + 10) cycle();
      i_cpu_halt = 1'b1;
      i_regfile_tx_done = 1'b1;
      fifo.push_back(8'h44);
      wait_idle(60, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL run_idle: not idle, want idle"); end
      n_checks++;
      if (en_cyc.size() != 10) begin
         n_fail++; $display("FAIL run_en_count: got %0d, want 10", en_cyc.size());
      end else if (en_cyc[0] != t + 1 || en_cyc[9] != t + 10) begin
         n_fail++; $display("FAIL run_en_window: got %0d..%0d, want %0d..%0d", en_cyc[0],
                            en_cyc[9], t + 1, t + 10);
      end
      n_checks++;
      if (start_cyc.size() != 2 || pop_cyc.size() != 2) begin
         n_fail++; $display("FAIL run_starts: starts=%0d pops=%0d, want 2 and 2",
                            start_cyc.size(), pop_cyc.size());
      end else if (start_cyc[0] != t + 11 || pop_cyc[1] != t + 13 || start_cyc[1] != t + 14) begin
         n_fail++;
         $display("FAIL run_timing: start@%0d D-pop@%0d start@%0d, want %0d %0d %0d",
                  start_cyc[0], pop_cyc[1], start_cyc[1], t + 11, t + 13, t + 14);
      end
      i_regfile_tx_done = 1'b0;
   endtask

   task automatic test_run_halted();
      bit ok;
      clear_log();
      i_cpu_halt = 1'b1;
      i_regfile_tx_done = 1'b1;
      fifo.push_back(8'h52);
      wait_idle(40, ok);
      n_checks++;
      if (!ok || en_cyc.size() != 0 || start_cyc.size() != 1) begin
         n_fail++; $display("FAIL run_halted: idle=%0b en=%0d starts=%0d, want 1 0 1", ok,
                            en_cyc.size(), start_cyc.size());
      end
      i_cpu_halt = 1'b0;
   endtask

   task automatic test_step();
      bit ok;
      int t;
      int n0;
      clear_log();
      i_regfile_tx_done = 1'b1;
      fifo.push_back(8'h53);
      wait_pops(1, 20, ok);
      t = ok ? pop_cyc[0] : cyc;
      wait_idle(40, ok);
      n_checks++;
      if (!ok || en_cyc.size() != 1 || start_cyc.size() != 1) begin
         n_fail++; $display("FAIL step_counts: idle=%0b en=%0d starts=%0d, want 1 1 1", ok,
                            en_cyc.size(), start_cyc.size());
      end else if (en_cyc[0] != t + 1 || start_cyc[0] != t + 2) begin
         n_fail++; $display("FAIL step_timing: en@%0d start@%0d, want %0d %0d", en_cyc[0],
                            start_cyc[0], t + 1, t + 2);
      end
      busy_n = 0;
      n0 = pop_cyc.size();
      fifo.push_back(8'h00);
      for (int i = 0; i < 6; i++) cycle();
      n_checks++;
      if (pop_cyc.size() != n0 + 1 || busy_n != 0 || start_cyc.size() != 1) begin
         n_fail++; $display("FAIL step_junk: pops=%0d busy=%0d starts=%0d, want %0d 0 1",
                            pop_cyc.size(), busy_n, start_cyc.size(), n0 + 1);
      end
   endtask

   task automatic test_load_gaps();
      bit ok;
      clear_log();
      gap_len = 3;
      stim = '{8'h4C, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      model_stream(stim);
      push_stim();
      wait_idle(200, ok);
      gap_len = 0;
      n_checks++;
      if (!ok || wr_addr.size() != 2 || done_cyc.size() != 1) begin
         n_fail++; $display("FAIL gaps_counts: idle=%0b writes=%0d done=%0d, want 1 2 1", ok,
                            wr_addr.size(), done_cyc.size());
      end
      for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
         n_checks++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL gaps_word%0d: got %h@%0d, want %h@%0d", i, wr_data[i], wr_addr[i],
                     exp_data[i], exp_addr[i]);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      bit ok;
      logic [46:0] obs;
      logic [31:0] w;
      clear_log();
      stim = '{8'h4C, 8'h03, 8'h00};
      for (int i = 0; i < 12; i++) stim.push_back(8'($urandom));
      push_stim();
      wait_pops(6, 40, ok);
      i_rst = 1'b1;
      fifo.delete();
      rx_if.rx_empty = 1'b1;
      cycle();
      obs = {o_imem_wr, o_imem_waddr, o_imem_wdata, o_cpu_en, o_regfile_tx_start,
             o_load_done, o_busy};
      n_checks++;
      if (!ok || obs !== '0 || rx_if.rx_rd !== 1'b0) begin
         n_fail++; $display("FAIL midrst_outputs: popped6=%0b got %h rd=%b, want 1 0 0", ok, obs,
                            rx_if.rx_rd);
      end
      i_rst = 1'b0;
      clear_log();
      w = $urandom;
      stim = '{8'h4C, 8'h01, 8'h00, w[7:0], w[15:8], w[23:16], w[31:24]};
      push_stim();
      wait_idle(60, ok);
      n_checks++;
      if (!ok || wr_addr.size() != 1) begin
         n_fail++; $display("FAIL midrst_reload: idle=%0b writes=%0d, want 1 1", ok,
                            wr_addr.size());
      end else if (wr_addr[0] !== 10'd0 || wr_data[0] !== w) begin
         n_fail++; $display("FAIL midrst_word: got %h@%0d, want %h@0", wr_data[0], wr_addr[0], w);
      end
   endtask

   task automatic test_random_stream(input int seq);
      bit ok;
      clear_log();
      i_cpu_halt = 1'b1;
      i_regfile_tx_done = 1'b1;
      gap_len = $urandom_range(0, 2);
      stim.delete();
      for (int k = 0; k < 8; k++) begin
         case ($urandom_range(0, 4))
            0: begin
               int n = $urandom_range(1, 4);
               stim.push_back(8'h4C); stim.push_back(8'(n)); stim.push_back(8'h00);
               for (int j = 0; j < 4 * n; j++) stim.push_back(8'($urandom));
            end
            1: stim.push_back(8'h44);
            2: stim.push_back(8'h53);
            3: stim.push_back(8'h52);
            default: begin
               logic [7:0] b;
               do b = 8'($urandom);
               while (b == 8'h4C || b == 8'h52 || b == 8'h53 || b == 8'h44);
               stim.push_back(b);
            end
         endcase
      end
      model_stream(stim);
      push_stim();
      wait_idle(2000, ok);
      gap_len = 0;
      n_checks++;
      if (!ok || wr_addr.size() != exp_addr.size()) begin
         n_fail++; $display("FAIL rand%0d_nwr: idle=%0b writes=%0d, want 1 %0d", seq, ok,
                            wr_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
         n_checks++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL rand%0d_word%0d: got %h@%0d, want %h@%0d", seq, i, wr_data[i],
                     wr_addr[i], exp_data[i], exp_addr[i]);
         end
      end
      n_checks++;
      if (done_cyc.size() != exp_done || start_cyc.size() != exp_start ||
          en_cyc.size() != exp_en) begin
         n_fail++;
         $display("FAIL rand%0d_events: done=%0d start=%0d en=%0d, want %0d %0d %0d", seq,
                  done_cyc.size(), start_cyc.size(), en_cyc.size(), exp_done, exp_start, exp_en);
      end
      i_cpu_halt = 1'b0;
      i_regfile_tx_done = 1'b0;
   endtask

   task automatic test_addr_wrap();
      bit ok;
      int nbad = 0;
      clear_log();
      stim = '{8'h4C, 8'h02, 8'h04};
      for (int i = 0; i < 4 * 1026; i++) stim.push_back(8'($urandom));
      model_stream(stim);
      push_stim();
      wait_idle(6000, ok);
      n_checks++;
      if (!ok || wr_addr.size() != 1026 || done_cyc.size() != 1) begin
         n_fail++; $display("FAIL wrap_counts: idle=%0b writes=%0d done=%0d, want 1 1026 1", ok,
                            wr_addr.size(), done_cyc.size());
      end
      for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) nbad++;
      end
      n_checks++;
      if (nbad != 0) begin
         n_fail++; $display("FAIL wrap_words: %0d wrong words, want 0", nbad);
      end
      n_checks++;
      if (wr_addr.size() < 1026) begin
         n_fail++; $display("FAIL wrap_tail: only %0d writes, want 1026", wr_addr.size());
      end else if (wr_addr[1024] !== 10'd0 || wr_addr[1025] !== 10'd1) begin
         n_fail++; $display("FAIL wrap_tail: addrs %0d,%0d, want 0,1", wr_addr[1024],
                            wr_addr[1025]);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      i_cpu_halt = 1'b0;
      i_regfile_tx_done = 1'b0;
      rx_if.rx_empty = 1'b1;
      rx_if.rx_data = 8'h00;
      test_reset();
      test_load_two();
      test_load_zero();
      test_run();
      test_run_halted();
      test_step();
      test_load_gaps();
      test_reset_mid_load();
      for (int s = 0; s < 6; s++) test_random_stream(s);
      test_addr_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
